// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the handshaked ALU: opcode encodings and the
// encoding of the control FSM states (IDLE / MUL / DONE).
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_EQ  = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_NOP = 4'd14;
    localparam logic [3:0] OP_SLT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Unsigned iterative shift-add multiplier. A start pulse captures the operands
// and clears the accumulator; each following cycle adds the (shifted)
// multiplicand when the current multiplier LSB is set. After WIDTH iterations
// the full 2*WIDTH-bit product is held in the accumulator until next start.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_start    load operands and begin (ignored state is overwritten)
//   i_a, i_b   multiplicand, multiplier (sampled on i_start)
//   o_busy     iterations in progress
//   o_last     current cycle performs the final iteration
//   o_done     product valid (set after the last iteration, cleared on start)
//   o_product  2*WIDTH-bit accumulator
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_last,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    // Operand capture and one shift-add step per busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == CNT_LAST) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_last    = r_busy && (r_cnt == CNT_LAST);
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// WIDTH-bit ALU with valid/ready handshake on both sides and a registered
// result. Single-cycle ops produce a result one cycle after acceptance and
// sustain one op per cycle while the consumer keeps up.
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined   -> opcode 13 runs the iterative multiplier (WIDTH+1 cycle latency)
//   undefined -> opcode 13 behaves as NOP, the FSM stays in IDLE
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (ctrl, x, y sampled on fire)
//   ctrl             opcode
//   x, y             operands A, B
//   out_valid/ready  result handshake
//   out              result
//   carry            carry / borrow / multiply-high flag
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;

    logic             w_slot_free;
    logic             w_fire;
    logic             w_consume;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SH_W-1:0]  w_sh;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_carry;
    logic             w_load;
    logic [WIDTH-1:0] w_load_out;
    logic             w_load_carry;

    // Output slot can take a new result if empty or being drained this cycle.
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !rst && (r_state == ST_IDLE) && w_slot_free;
    assign w_fire      = in_valid && in_ready;
    assign w_consume   = r_out_valid && out_ready;

    // Carry and borrow fall out of the extra top bit.
    assign w_sum  = {1'b0, x} + {1'b0, y};
    assign w_diff = {1'b0, x} - {1'b0, y};
    assign w_sh   = x[SH_W-1:0];

`ifdef ALU_PIPE_MUL_EN
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_last;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (x),
        .i_b       (y),
        .o_busy    (w_mul_busy),
        .o_last    (w_mul_last),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`endif

    // Single-cycle operation decode.
    always_comb begin
        w_alu_out   = '0;
        w_alu_carry = 1'b0;
        case (ctrl)
            OP_ADD: begin
                w_alu_out   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_out   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            OP_AND: w_alu_out = x & y;
            OP_OR:  w_alu_out = x | y;
            OP_NOT: w_alu_out = ~x;
            OP_XOR: w_alu_out = x ^ y;
            OP_NOR: w_alu_out = ~(x | y);
            OP_SLL: w_alu_out = y << w_sh;
            OP_SRL: w_alu_out = y >> w_sh;
            OP_SRA: w_alu_out = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_ROL: w_alu_out = {x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR: w_alu_out = {x[0], x[WIDTH-1:1]};
            OP_EQ:  w_alu_out = {{(WIDTH-1){1'b0}}, (x == y)};
            OP_MUL: w_alu_out = '0;
            OP_NOP: w_alu_out = '0;
            OP_SLT: w_alu_out = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            default: begin
                w_alu_out   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // FSM next state and selection of what gets loaded into the output slot.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_out   = w_alu_out;
        w_load_carry = w_alu_carry;
`ifdef ALU_PIPE_MUL_EN
        w_mul_start  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
`ifdef ALU_PIPE_MUL_EN
                    if (ctrl == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_load = 1'b1;
                    end
`else
                    w_load = 1'b1;
`endif
                end else begin
                    w_load = 1'b0;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = ST_DONE;
                end else if (!w_mul_busy) begin
                    // Multiplier not running: recover rather than hang.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end
            ST_DONE: begin
                if (w_mul_done && w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_out   = w_mul_product[WIDTH-1:0];
                    w_load_carry = |w_mul_product[2*WIDTH-1:WIDTH];
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output slot: load a new result, or empty it once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out       <= w_load_out;
            r_carry     <= w_load_carry;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign carry     = r_carry;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboard bench for alu_pipe: an 8-bit and a 16-bit instance share clock
// and reset. Each accepted op pushes the reference result into a queue; a
// monitor per instance pops and compares whenever a result is consumed, and
// checks that a stalled result stays stable. Behaviour follows
// ALU_PIPE_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rnd = 1'b0;

    logic        in_valid8 = 1'b0;
    logic        out_ready8 = 1'b1;
    logic [3:0]  ctrl8 = 4'd0;
    logic [7:0]  x8 = 8'h00;
    logic [7:0]  y8 = 8'h00;
    logic        in_ready8;
    logic        o_valid8;
    logic [7:0]  o_out8;
    logic        o_carry8;

    logic        in_valid16 = 1'b0;
    logic        out_ready16 = 1'b1;
    logic [3:0]  ctrl16 = 4'd0;
    logic [15:0] x16 = 16'h0000;
    logic [15:0] y16 = 16'h0000;
    logic        in_ready16;
    logic        o_valid16;
    logic [15:0] o_out16;
    logic        o_carry16;

    exp_t q8[$];
    exp_t q16[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .ctrl(ctrl8), .x(x8), .y(y8), .out_valid(o_valid8),
        .out_ready(out_ready8), .out(o_out8), .carry(o_carry8)
    );

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .ctrl(ctrl16), .x(x16), .y(y16), .out_valid(o_valid16),
        .out_ready(out_ready16), .out(o_out16), .carry(o_carry16)
    );

    always #5 clk = ~clk;

    // Reference: result {carry, out} of one op on w-bit operands.
    function automatic logic [16:0] ref_model(input int w, input logic [3:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m  = (longint'(1) << w) - 1;
        longint r  = 0;
        longint sa;
        longint sb;
        longint p;
        bit     c  = 1'b0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r > m); end
            4'd1:  begin r = ua - ub; c = (ua < ub); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ~ua;
            4'd5:  r = ua ^ ub;
            4'd6:  r = ~(ua | ub);
            4'd7:  r = ub << (ua % w);
            4'd8:  r = ub >> (ua % w);
            4'd9:  r = (ua >> 1) | (ua & (longint'(1) << (w - 1)));
            4'd10: r = (ua << 1) | (ua >> (w - 1));
            4'd11: r = (ua >> 1) | ((ua & 1) << (w - 1));
            4'd12: r = (ua == ub) ? 1 : 0;
            4'd13: begin
`ifdef ALU_PIPE_MUL_EN
                p = ua * ub;
                r = p;
                c = ((p >> w) != 0);
`else
                r = 0;
`endif
            end
            4'd15: begin
                sa = (ua > m / 2) ? ua - (m + 1) : ua;
                sb = (ub > m / 2) ? ub - (m + 1) : ub;
                r  = (sa < sb) ? 1 : 0;
            end
            default: r = 0;
        endcase
        r = r & m;
        return {c, r[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        in_valid8 = 1'b1; ctrl8 = op; x8 = a; y8 = b;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            in_valid8 = 1'b0;
            n_cmp++; n_bad++;
            $display("FAIL issue8_timeout: in_ready stayed 0 for op %0d", op);
        end else begin
            e.op = op; e.a = {8'h00, a}; e.b = {8'h00, b};
            e.r  = ref_model(8, op, e.a, e.b);
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   n;
        in_valid16 = 1'b1; ctrl16 = op; x16 = a; y16 = b;
        n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready16) begin
            in_valid16 = 1'b0;
            n_cmp++; n_bad++;
            $display("FAIL issue16_timeout: in_ready stayed 0 for op %0d", op);
        end else begin
            e.op = op; e.a = a; e.b = b;
            e.r  = ref_model(16, op, a, b);
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    // Monitor for the 8-bit instance.
    logic        hold8 = 1'b0;
    logic [16:0] h_r8 = 17'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold8 = 1'b0;
        end else begin
            if (hold8) begin
                chk("hold8_valid", 32'(o_valid8), 32'd1);
                chk("hold8_result", 32'({o_carry8, 8'h00, o_out8}), 32'(h_r8));
            end
            if (o_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL res8_unexpected: got %h, expected no result", o_out8);
                end else begin
                    e = q8.pop_front();
                    chk($sformatf("res8 op=%0d a=%h b=%h", e.op, e.a[7:0], e.b[7:0]),
                        32'({o_carry8, 8'h00, o_out8}), 32'(e.r));
                end
            end
            hold8 = o_valid8 && !out_ready8;
            h_r8  = {o_carry8, 8'h00, o_out8};
        end
    end

    // Monitor for the 16-bit instance.
    logic        hold16 = 1'b0;
    logic [16:0] h_r16 = 17'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold16 = 1'b0;
        end else begin
            if (hold16) begin
                chk("hold16_valid", 32'(o_valid16), 32'd1);
                chk("hold16_result", 32'({o_carry16, o_out16}), 32'(h_r16));
            end
            if (o_valid16 && out_ready16) begin
                if (q16.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL res16_unexpected: got %h, expected no result", o_out16);
                end else begin
                    e = q16.pop_front();
                    chk($sformatf("res16 op=%0d a=%h b=%h", e.op, e.a, e.b),
                        32'({o_carry16, o_out16}), 32'(e.r));
                end
            end
            hold16 = o_valid16 && !out_ready16;
            h_r16  = {o_carry16, o_out16};
        end
    end

    // Random consumer back-pressure (offset so the main thread's settings win).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd) begin
                out_ready8  = ($urandom_range(0, 3) != 0);
                out_ready16 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: run did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int lat;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready8", 32'(in_ready8), 32'd0);
        chk("rst_out_valid8", 32'(o_valid8), 32'd0);
        chk("rst_out8", 32'(o_out8), 32'd0);
        chk("rst_carry8", 32'(o_carry8), 32'd0);
        chk("rst_out_valid16", 32'(o_valid16), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready8_after_rst", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;

        // Add / subtract / signed compare, with single-cycle latency.
        issue8(4'd0, 8'hFF, 8'h01);
        chk("add_latency", 32'(o_valid8), 32'd1);
        issue8(4'd0, 8'h03, 8'h0A);
        issue8(4'd1, 8'h0E, 8'h07);
        issue8(4'd1, 8'h03, 8'h05);
        issue8(4'd15, 8'h80, 8'h01);
        issue8(4'd12, 8'h5A, 8'h5A);

        // Stall the consumer, then release with back-to-back ops.
        repeat (2) @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        issue8(4'd0, 8'h5A, 8'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready8), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready8 = 1'b1;
        issue8(4'd5, 8'hA5, 8'h0F);
        chk("burst_valid0", 32'(o_valid8), 32'd1);
        issue8(4'd7, 8'h03, 8'h81);
        chk("burst_valid1", 32'(o_valid8), 32'd1);
        issue8(4'd15, 8'h01, 8'hFF);
        chk("burst_valid2", 32'(o_valid8), 32'd1);
        issue8(4'd6, 8'h0C, 8'h30);
        chk("burst_valid3", 32'(o_valid8), 32'd1);

        // Opcode 13 latency and results.
        repeat (3) @(posedge clk);
        #1;
        issue8(4'd13, 8'h0F, 8'h11);
        lat = 1;
        while (!o_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef ALU_PIPE_MUL_EN
        chk("mul_latency", 32'(lat), 32'd9);
`else
        chk("op13_latency", 32'(lat), 32'd1);
`endif
        issue8(4'd13, 8'h10, 8'h10);
        n = 0;
        while (q8.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;

        // Reset while work is in flight.
`ifdef ALU_PIPE_MUL_EN
        issue8(4'd13, 8'hC3, 8'h5A);
        repeat (4) @(posedge clk);
        #1;
`else
        out_ready8 = 1'b0;
        issue8(4'd0, 8'h12, 8'h34);
`endif
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(o_valid8), 32'd0);
        chk("midrst_out", 32'(o_out8), 32'd0);
        chk("midrst_in_ready", 32'(in_ready8), 32'd0);
        q8.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("in_ready_after_midrst", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;
        issue8(4'd0, 8'h01, 8'h01);

        // 16-bit shifts and rotates.
        issue16(4'd7, 16'h0004, 16'h00F3);
        chk("shift16_latency", 32'(o_valid16), 32'd1);
        issue16(4'd8, 16'h0008, 16'hB300);
        issue16(4'd9, 16'h8003, 16'h0000);
        issue16(4'd10, 16'h8001, 16'h0000);
        issue16(4'd11, 16'h0001, 16'h0000);
        issue16(4'd0, 16'hFFFF, 16'h0002);

        // Randomized traffic with random back-pressure and idle gaps.
        rnd = 1'b1;
        for (int i = 0; i < 250; i++) begin
            issue8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ctrl8 = 4'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 150; i++) begin
            issue16(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ctrl16 = 4'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
                @(posedge clk);
                #1;
            end
        end

        rnd = 1'b0;
        @(posedge clk);
        #1;
        out_ready8  = 1'b1;
        out_ready16 = 1'b1;
        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
